// File: rtl/column_write_driver.sv
`default_nettype none
// ============================================================================
// Module   : column_write_driver
// Purpose  : Write-side column driver for the SRAM bitcell array. Accepts one
//            word write (word index + data) over a valid/ready handshake and
//            sequences precharge, bitline drive and recovery phases, driving
//            per-column write data and write enables. Column mapping matches
//            the read column mux: bit i of word w sits on column
//            w*WORD_SIZE+i.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_valid/req_ready   - write request handshake (ready = IDLE)
//            word_sel, data_in     - target word index and write data
//            precharge_en          - bitline precharge enable
//            col_wdata, col_wen    - per-column write data / write enable
//            done                  - one-cycle pulse at end of a write
// Revision : 1.0  initial release
// ============================================================================
module column_write_driver #(
  parameter int WORD_SIZE    = 4,
  parameter int NUM_WORDS    = 16,
  parameter int NUM_COLS     = 64,
  parameter int PRE_CYCLES   = 1,
  parameter int DRIVE_CYCLES = 2,
  parameter int REC_CYCLES   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_WORDS)-1:0] word_sel,
  input  logic [WORD_SIZE-1:0]         data_in,
  output logic                         precharge_en,
  output logic [NUM_COLS-1:0]          col_wdata,
  output logic [NUM_COLS-1:0]          col_wen,
  output logic                         done
);

  localparam int WSEL_W  = $clog2(NUM_WORDS);
  localparam int MAX_LEN = (PRE_CYCLES > DRIVE_CYCLES)
                         ? ((PRE_CYCLES > REC_CYCLES) ? PRE_CYCLES : REC_CYCLES)
                         : ((DRIVE_CYCLES > REC_CYCLES) ? DRIVE_CYCLES : REC_CYCLES);
  // The counter holds (phase length - 1), so it only needs to reach MAX_LEN-1.
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(REC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DRIVE = 3'd2,
    S_REC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [WSEL_W-1:0]     word_q,  word_d;
  logic [WORD_SIZE-1:0]  data_q,  data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. Each timed phase exits when the counter reaches zero
  // and loads the length of the following phase on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          word_d  = word_sel;
          data_d  = data_in;
          cnt_d   = PRE_LOAD;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == '0) begin
          cnt_d   = DRIVE_LOAD;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = REC_LOAD;
          state_d = S_REC;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_REC: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so nothing on the input side can
  // reach an output combinationally, and an async reset clears them at once.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    precharge_en = (state_q == S_PRE);
    done         = (state_q == S_DONE);
  end

  // Column drive: only the selected word's slice is enabled. An out-of-range
  // index matches no word, so the sequence still runs with col_wen all zero.
  always_comb begin
    col_wen   = '0;
    col_wdata = '0;
    if (state_q == S_DRIVE) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (word_q == WSEL_W'(w)) begin
          col_wen[w*WORD_SIZE +: WORD_SIZE]   = '1;
          col_wdata[w*WORD_SIZE +: WORD_SIZE] = data_q;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_column_write_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_write_driver
// Purpose  : Self-checking bench for column_write_driver. Directed writes push
//            hand-computed expected column patterns into a queue; a monitor
//            pops an entry on each accepted request and checks every cycle of
//            the write sequence against the documented phase timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_column_write_driver;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  word_sel;
  logic [3:0]  data_in;
  logic        precharge_en;
  logic [63:0] col_wdata;
  logic [63:0] col_wen;
  logic        done;

  column_write_driver #(
    .WORD_SIZE   (4),
    .NUM_WORDS   (16),
    .NUM_COLS    (64),
    .PRE_CYCLES  (1),
    .DRIVE_CYCLES(2),
    .REC_CYCLES  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .word_sel    (word_sel),
    .data_in     (data_in),
    .precharge_en(precharge_en),
    .col_wdata   (col_wdata),
    .col_wen     (col_wen),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  w;
    logic [3:0]  d;
    logic [63:0] wen;
    logic [63:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int done_cnt = 0;

  // Monitor bookkeeping.
  logic active = 1'b0;
  int   acc_cyc = 0;
  int   rel = 0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("wen_vs_precharge", col_wen & {64{precharge_en}}, 64'h0);
    if (!rst_n) begin
      active = 1'b0;
      chk("rst_wen",   col_wen,      64'h0);
      chk("rst_wdata", col_wdata,    64'h0);
      chk("rst_pre",   {63'h0, precharge_en}, 64'h0);
      chk("rst_done",  {63'h0, done},         64'h0);
      chk("rst_ready", {63'h0, req_ready},    64'h1);
    end else begin
      if (done) done_cnt++;
      if (active) begin
        rel = cyc - acc_cyc;
        chk("seq_pre",   {63'h0, precharge_en}, {63'h0, (rel == 1)});
        chk("seq_wen",   col_wen,   (rel == 2 || rel == 3) ? cur.wen   : 64'h0);
        chk("seq_wdata", col_wdata, (rel == 2 || rel == 3) ? cur.wdata : 64'h0);
        chk("seq_done",  {63'h0, done},      {63'h0, (rel == 5)});
        chk("seq_ready", {63'h0, req_ready}, 64'h0);
        if (rel == 2 || rel == 3)
          chk("readback", {60'h0, col_wdata[cur.w*4 +: 4]}, {60'h0, cur.d});
        if (rel >= 5) active = 1'b0;
      end else begin
        chk("idle_pre",   {63'h0, precharge_en}, 64'h0);
        chk("idle_wen",   col_wen,   64'h0);
        chk("idle_wdata", col_wdata, 64'h0);
        chk("idle_done",  {63'h0, done},      64'h0);
        chk("idle_ready", {63'h0, req_ready}, 64'h1);
      end
      if (!active && req_valid && req_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 64'h1, 64'h0);
        end else begin
          cur     = exp_q.pop_front();
          active  = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  // Issue one write at posedge+1 and wait (bounded) for the accepting edge.
  task automatic do_write(input logic [3:0] w, input logic [3:0] d,
                          input logic [63:0] wen, input logic [63:0] wdata,
                          output int acc);
    exp_t e;
    bit   got;
    e.w = w; e.d = d; e.wen = wen; e.wdata = wdata;
    word_sel  = w;
    data_in   = d;
    req_valid = 1'b1;
    exp_q.push_back(e);
    got = 1'b0;
    acc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
  endtask

  int a1, a2, tmp;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    word_sel  = 4'h0;
    data_in   = 4'h0;

    // 1. Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wen",   col_wen,   64'h0);
    chk("reset_wdata", col_wdata, 64'h0);
    chk("reset_pre",   {63'h0, precharge_en}, 64'h0);
    chk("reset_done",  {63'h0, done},         64'h0);
    chk("reset_ready", {63'h0, req_ready},    64'h1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2. Word 0, data A
    do_write(4'd0, 4'hA, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_000A, tmp);
    req_valid = 1'b0;

    // 3. Word 15, data 5
    do_write(4'd15, 4'h5, 64'hF000_0000_0000_0000, 64'h5000_0000_0000_0000, tmp);
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // 4. Back-to-back with req_valid held high
    do_write(4'd3, 4'h9, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_9000, a1);
    do_write(4'd7, 4'hC, 64'h0000_0000_F000_0000, 64'h0000_0000_C000_0000, a2);
    req_valid = 1'b0;
    chk("b2b_accept_gap", 64'(a2 - a1), 64'd6);

    // 5. Inputs change during PRE; captured values must be used
    do_write(4'd2, 4'h3, 64'h0000_0000_0000_0F00, 64'h0000_0000_0000_0300, tmp);
    word_sel  = 4'd9;
    data_in   = 4'hF;
    req_valid = 1'b0;

    // 6. Reset pulsed during DRIVE, then a normal write
    do_write(4'd5, 4'h6, 64'h0000_0000_00F0_0000, 64'h0000_0000_0060_0000, tmp);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drive_before_rst", col_wen, 64'h0000_0000_00F0_0000);
    rst_n = 1'b0;
    #1;
    chk("midrst_wen",   col_wen,   64'h0);
    chk("midrst_wdata", col_wdata, 64'h0);
    chk("midrst_done",  {63'h0, done},      64'h0);
    chk("midrst_ready", {63'h0, req_ready}, 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_write(4'd10, 4'hB, 64'h0000_0F00_0000_0000, 64'h0000_0B00_0000_0000, tmp);
    req_valid = 1'b0;

    repeat (10) @(negedge clk);
    chk("queue_empty",   64'(exp_q.size()), 64'd0);
    chk("monitor_idle",  {63'h0, active},   64'h0);
    chk("done_pulses",   64'(done_cnt),     64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
